// File: rtl/axis_pkt_arbiter_pkg.sv
// rtl/axis_pkt_arbiter_pkg.sv - shared widths, FSM state and round-robin pick function
package axis_pkt_arbiter_pkg;
  localparam int AXIS_DATA_W = 256;
  localparam int AXIS_LEN_W  = 16;
  localparam int AXIS_PORT_W = 8;
  localparam int MAX_IN      = 4;
  localparam int PTR_W       = 2;

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

  // First requester at or after ptr, wrapping at n; result is one-hot or zero.
  function automatic logic [MAX_IN-1:0] rr_pick(input logic [MAX_IN-1:0] req,
                                                input logic [PTR_W-1:0]  ptr,
                                                input int                n);
    logic [MAX_IN-1:0] gnt;
    logic              found;
    logic [PTR_W-1:0]  idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_IN; k++) begin
      idx = PTR_W'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/axis_pkt_arbiter_rr_arbiter.sv
// rtl/axis_pkt_arbiter_rr_arbiter.sv - combinational round-robin pick with registered pointer
module axis_pkt_arbiter_rr_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] i_req,
  input  logic              i_done,
  input  logic [PTR_W-1:0]  i_done_idx,
  output logic [NUM_IN-1:0] o_grant
);
  logic [PTR_W-1:0]  r_ptr;
  logic [MAX_IN-1:0] w_req_ext;
  logic [MAX_IN-1:0] w_pick;
  logic [MAX_IN-1:0] w_pick_unused;

  assign w_req_ext     = MAX_IN'(i_req);
  assign w_pick        = rr_pick(w_req_ext, r_ptr, NUM_IN);
  assign w_pick_unused = w_pick;
  assign o_grant       = w_pick[NUM_IN-1:0];

  // Pointer moves only when a packet completes, to the port after its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_done) begin
      r_ptr <= (i_done_idx == PTR_W'(NUM_IN - 1)) ? '0 : i_done_idx + PTR_W'(1);
    end
  end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-granular round-robin AXI4-Stream arbiter with per-input counters
module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DATA_W = AXIS_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [NUM_IN*DATA_W-1:0]     S_AXIS_DAT_TDATA,
  input  logic [NUM_IN*DATA_W/8-1:0]   S_AXIS_DAT_TSTRB,
  input  logic [NUM_IN-1:0]            S_AXIS_DAT_TLAST,
  input  logic [NUM_IN-1:0]            S_AXIS_DAT_TVALID,
  output logic [NUM_IN-1:0]            S_AXIS_DAT_TREADY,
  input  logic [NUM_IN*AXIS_LEN_W-1:0] S_AXIS_LEN_TDATA,
  input  logic [NUM_IN*AXIS_PORT_W-1:0] S_AXIS_SPT_TDATA,
  input  logic [NUM_IN*AXIS_PORT_W-1:0] S_AXIS_DPT_TDATA,
  input  logic [NUM_IN-1:0]            S_AXIS_ERR_TDATA,
  output logic [DATA_W-1:0]            M_AXIS_DAT_TDATA,
  output logic [DATA_W/8-1:0]          M_AXIS_DAT_TSTRB,
  output logic                         M_AXIS_DAT_TLAST,
  output logic                         M_AXIS_DAT_TVALID,
  input  logic                         M_AXIS_DAT_TREADY,
  output logic [AXIS_LEN_W-1:0]        M_AXIS_LEN_TDATA,
  output logic [AXIS_PORT_W-1:0]       M_AXIS_SPT_TDATA,
  output logic [AXIS_PORT_W-1:0]       M_AXIS_DPT_TDATA,
  output logic                         M_AXIS_ERR_TDATA,
  output logic [NUM_IN-1:0]            GRANT,
  output logic [NUM_IN*CNT_W-1:0]      PKT_CNT
);
  localparam int STRB_W = DATA_W / 8;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_IN-1:0] r_grant;
  logic [NUM_IN-1:0] w_pick;
  logic [CNT_W-1:0]  r_pkt_cnt [NUM_IN];
  logic [PTR_W-1:0]  w_g_idx;
  logic              w_xfer;
  logic              w_done;

  always_comb begin
    w_g_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant[i]) w_g_idx = PTR_W'(i);
    end
  end

  assign w_xfer = (r_state == PASS) && (|(S_AXIS_DAT_TVALID & r_grant)) && M_AXIS_DAT_TREADY;
  assign w_done = w_xfer && (|(S_AXIS_DAT_TLAST & r_grant));

  axis_pkt_arbiter_rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .i_req      (S_AXIS_DAT_TVALID),
    .i_done     (w_done),
    .i_done_idx (w_g_idx),
    .o_grant    (w_pick)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        r_grant <= w_pick;
      end else if (w_done) begin
        r_grant <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (|S_AXIS_DAT_TVALID) w_state_nxt = PASS;
      PASS: if (w_done) w_state_nxt = IDLE;
    endcase
  end

  // Zero-latency mux; everything stays at 0 while no port owns the egress.
  always_comb begin
    M_AXIS_DAT_TDATA  = '0;
    M_AXIS_DAT_TSTRB  = '0;
    M_AXIS_DAT_TLAST  = 1'b0;
    M_AXIS_DAT_TVALID = 1'b0;
    M_AXIS_LEN_TDATA  = '0;
    M_AXIS_SPT_TDATA  = '0;
    M_AXIS_DPT_TDATA  = '0;
    M_AXIS_ERR_TDATA  = 1'b0;
    S_AXIS_DAT_TREADY = '0;
    if (r_state == PASS) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_grant[i]) begin
          M_AXIS_DAT_TDATA     = S_AXIS_DAT_TDATA[i*DATA_W +: DATA_W];
          M_AXIS_DAT_TSTRB     = S_AXIS_DAT_TSTRB[i*STRB_W +: STRB_W];
          M_AXIS_DAT_TLAST     = S_AXIS_DAT_TLAST[i];
          M_AXIS_DAT_TVALID    = S_AXIS_DAT_TVALID[i];
          M_AXIS_LEN_TDATA     = S_AXIS_LEN_TDATA[i*AXIS_LEN_W +: AXIS_LEN_W];
          M_AXIS_SPT_TDATA     = S_AXIS_SPT_TDATA[i*AXIS_PORT_W +: AXIS_PORT_W];
          M_AXIS_DPT_TDATA     = S_AXIS_DPT_TDATA[i*AXIS_PORT_W +: AXIS_PORT_W];
          M_AXIS_ERR_TDATA     = S_AXIS_ERR_TDATA[i];
          S_AXIS_DAT_TREADY[i] = M_AXIS_DAT_TREADY;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_IN; i++) r_pkt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (w_done && r_grant[i]) r_pkt_cnt[i] <= r_pkt_cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cnt_out
    assign PKT_CNT[gi*CNT_W +: CNT_W] = r_pkt_cnt[gi];
  end

  assign GRANT = r_grant;
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - scoreboard bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;
  localparam int NUM_IN = 2;
  localparam int DATA_W = 256;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [15:0]       len;
    logic [7:0]        spt;
    logic [7:0]        dpt;
    logic              err;
  } beat_t;

  logic                     ACLK = 1'b0;
  logic                     ARESETN = 1'b0;
  logic [NUM_IN*DATA_W-1:0] S_AXIS_DAT_TDATA;
  logic [NUM_IN*STRB_W-1:0] S_AXIS_DAT_TSTRB;
  logic [NUM_IN-1:0]        S_AXIS_DAT_TLAST;
  logic [NUM_IN-1:0]        S_AXIS_DAT_TVALID;
  logic [NUM_IN-1:0]        S_AXIS_DAT_TREADY;
  logic [NUM_IN*16-1:0]     S_AXIS_LEN_TDATA;
  logic [NUM_IN*8-1:0]      S_AXIS_SPT_TDATA;
  logic [NUM_IN*8-1:0]      S_AXIS_DPT_TDATA;
  logic [NUM_IN-1:0]        S_AXIS_ERR_TDATA;
  logic [DATA_W-1:0]        M_AXIS_DAT_TDATA;
  logic [STRB_W-1:0]        M_AXIS_DAT_TSTRB;
  logic                     M_AXIS_DAT_TLAST;
  logic                     M_AXIS_DAT_TVALID;
  logic                     M_AXIS_DAT_TREADY = 1'b1;
  logic [15:0]              M_AXIS_LEN_TDATA;
  logic [7:0]               M_AXIS_SPT_TDATA;
  logic [7:0]               M_AXIS_DPT_TDATA;
  logic                     M_AXIS_ERR_TDATA;
  logic [NUM_IN-1:0]        GRANT;
  logic [NUM_IN*CNT_W-1:0]  PKT_CNT;

  beat_t             cur [NUM_IN];
  logic [NUM_IN-1:0] cur_v;
  logic [NUM_IN-1:0] fired;
  beat_t             src_q0[$];
  beat_t             src_q1[$];
  beat_t             exp_q[$];
  int                checks = 0;
  int                failures = 0;
  int                gnt_err = 0;
  int                n;

  axis_pkt_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_DAT_TDATA(S_AXIS_DAT_TDATA), .S_AXIS_DAT_TSTRB(S_AXIS_DAT_TSTRB),
    .S_AXIS_DAT_TLAST(S_AXIS_DAT_TLAST), .S_AXIS_DAT_TVALID(S_AXIS_DAT_TVALID),
    .S_AXIS_DAT_TREADY(S_AXIS_DAT_TREADY), .S_AXIS_LEN_TDATA(S_AXIS_LEN_TDATA),
    .S_AXIS_SPT_TDATA(S_AXIS_SPT_TDATA), .S_AXIS_DPT_TDATA(S_AXIS_DPT_TDATA),
    .S_AXIS_ERR_TDATA(S_AXIS_ERR_TDATA),
    .M_AXIS_DAT_TDATA(M_AXIS_DAT_TDATA), .M_AXIS_DAT_TSTRB(M_AXIS_DAT_TSTRB),
    .M_AXIS_DAT_TLAST(M_AXIS_DAT_TLAST), .M_AXIS_DAT_TVALID(M_AXIS_DAT_TVALID),
    .M_AXIS_DAT_TREADY(M_AXIS_DAT_TREADY), .M_AXIS_LEN_TDATA(M_AXIS_LEN_TDATA),
    .M_AXIS_SPT_TDATA(M_AXIS_SPT_TDATA), .M_AXIS_DPT_TDATA(M_AXIS_DPT_TDATA),
    .M_AXIS_ERR_TDATA(M_AXIS_ERR_TDATA), .GRANT(GRANT), .PKT_CNT(PKT_CNT)
  );

  always #5 ACLK = ~ACLK;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
    assign S_AXIS_DAT_TDATA[gi*DATA_W +: DATA_W] = cur[gi].data;
    assign S_AXIS_DAT_TSTRB[gi*STRB_W +: STRB_W] = cur[gi].strb;
    assign S_AXIS_DAT_TLAST[gi]                  = cur[gi].last;
    assign S_AXIS_LEN_TDATA[gi*16 +: 16]         = cur[gi].len;
    assign S_AXIS_SPT_TDATA[gi*8 +: 8]           = cur[gi].spt;
    assign S_AXIS_DPT_TDATA[gi*8 +: 8]           = cur[gi].dpt;
    assign S_AXIS_ERR_TDATA[gi]                  = cur[gi].err;
  end
  assign S_AXIS_DAT_TVALID = cur_v;

  function automatic beat_t mk(int p, int k, logic last, int tag, logic special);
    beat_t b;
    b = '0;
    b.data = (DATA_W'(tag) << 16) | (DATA_W'(k) << 8) | DATA_W'(p);
    b.data[DATA_W-1 -: 8] = 8'hA5 ^ 8'(k);
    b.strb = special ? ({STRB_W{1'b1}} >> (8 * k)) : {STRB_W{1'b1}};
    b.last = last;
    b.len  = special ? 16'd64 : 16'(32 * (k + 1));
    b.spt  = special ? 8'd3 : 8'(p);
    b.dpt  = special ? 8'd7 : 8'(p + 4);
    b.err  = special;
    return b;
  endfunction

  task automatic push_src(input int p, input beat_t b);
    if (p == 0) src_q0.push_back(b);
    else        src_q1.push_back(b);
  endtask

  task automatic send_pkt(input int p, input int nb, input int tag, input logic special);
    for (int k = 0; k < nb; k++) push_src(p, mk(p, k, k == nb - 1, tag, special));
  endtask

  task automatic expect_pkt(input int p, input int nb, input int tag, input logic special);
    for (int k = 0; k < nb; k++) exp_q.push_back(mk(p, k, k == nb - 1, tag, special));
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_drain(input int bound, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < bound) begin
      @(negedge ACLK); #1;
      cyc++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic settle();
    @(negedge ACLK); #1;
  endtask

  task automatic wait_src0(input int target);
    int c;
    c = 0;
    while (src_q0.size() != target && c < 200) begin
      @(negedge ACLK); #1;
      c++;
    end
    chk("src0_wait", 64'(src_q0.size()), 64'(target));
  endtask

  // Source driver: pops a beat after each observed handshake, presents the next one.
  initial begin
    logic rst_at_edge;
    cur_v = '0;
    for (int i = 0; i < NUM_IN; i++) cur[i] = '0;
    forever begin
      @(posedge ACLK);
      rst_at_edge = ARESETN;
      #1;
      if (rst_at_edge && fired[0] && src_q0.size() > 0) void'(src_q0.pop_front());
      if (rst_at_edge && fired[1] && src_q1.size() > 0) void'(src_q1.pop_front());
      if (src_q0.size() > 0) begin cur[0] = src_q0[0]; cur_v[0] = 1'b1; end
      else begin cur[0] = '0; cur_v[0] = 1'b0; end
      if (src_q1.size() > 0) begin cur[1] = src_q1[0]; cur_v[1] = 1'b1; end
      else begin cur[1] = '0; cur_v[1] = 1'b0; end
    end
  end

  initial begin
    fired = '0;
    forever begin
      @(negedge ACLK);
      fired = S_AXIS_DAT_TVALID & S_AXIS_DAT_TREADY;
    end
  end

  // Monitor: every accepted egress beat is compared with the head of the scoreboard.
  initial begin
    beat_t got;
    beat_t want;
    forever begin
      @(negedge ACLK);
      if (ARESETN && M_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY) begin
        got = {M_AXIS_DAT_TDATA, M_AXIS_DAT_TSTRB, M_AXIS_DAT_TLAST, M_AXIS_LEN_TDATA,
               M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA, M_AXIS_ERR_TDATA};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got=%h", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL beat got=%h want=%h", got, want);
          end
        end
      end
      if (!$onehot0(GRANT)) gnt_err++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset with both ports valid, then release
    send_pkt(0, 2, 1, 1'b0);
    send_pkt(1, 1, 1, 1'b0);
    expect_pkt(0, 2, 1, 1'b0);
    expect_pkt(1, 1, 1, 1'b0);
    repeat (3) begin @(negedge ACLK); #1; end
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_tready", 64'(S_AXIS_DAT_TREADY), 64'd0);
    chk("rst_mvalid", 64'(M_AXIS_DAT_TVALID), 64'd0);
    chk("rst_cnt", 64'(PKT_CNT), 64'd0);
    ARESETN = 1'b1;
    settle();
    chk("t1_grant", 64'(GRANT), 64'b01);
    chk("t1_tready", 64'(S_AXIS_DAT_TREADY), 64'b01);
    wait_drain(50, n);
    settle();
    chk("t1_cnt", 64'(PKT_CNT), {48'd0, 8'd1, 8'd1});

    // 2: both ports continuously valid, 3-beat packets
    send_pkt(0, 3, 2, 1'b0);
    send_pkt(1, 3, 2, 1'b0);
    send_pkt(0, 3, 3, 1'b0);
    send_pkt(1, 3, 3, 1'b0);
    expect_pkt(0, 3, 2, 1'b0);
    expect_pkt(1, 3, 2, 1'b0);
    expect_pkt(0, 3, 3, 1'b0);
    expect_pkt(1, 3, 3, 1'b0);
    wait_drain(100, n);
    chk("t2_cycles", 64'(n), 64'd16);
    settle();
    chk("t2_grant_idle", 64'(GRANT), 64'd0);
    chk("t2_cnt", 64'(PKT_CNT), {48'd0, 8'd3, 8'd3});

    // 3: owner gap mid-packet while the other port waits
    push_src(0, mk(0, 0, 1'b0, 4, 1'b0));
    send_pkt(1, 1, 4, 1'b0);
    expect_pkt(0, 3, 4, 1'b0);
    expect_pkt(1, 1, 4, 1'b0);
    wait_src0(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK); #1;
      chk("t3_grant_hold", 64'(GRANT), 64'b01);
      chk("t3_no_egress", 64'(M_AXIS_DAT_TVALID), 64'd0);
    end
    push_src(0, mk(0, 1, 1'b0, 4, 1'b0));
    push_src(0, mk(0, 2, 1'b1, 4, 1'b0));
    wait_drain(100, n);
    settle();
    chk("t3_cnt", 64'(PKT_CNT), {48'd0, 8'd4, 8'd4});

    // 4: egress backpressure toggling, sideband LEN=64 SPT=3 DPT=7 ERR=1
    send_pkt(0, 4, 5, 1'b1);
    expect_pkt(0, 4, 5, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge ACLK); #2;
      M_AXIS_DAT_TREADY = ~M_AXIS_DAT_TREADY;
      @(negedge ACLK); #1;
      if (GRANT == 2'b01) chk("t4_tready_follow", 64'(S_AXIS_DAT_TREADY), {62'd0, 1'b0, M_AXIS_DAT_TREADY});
    end
    M_AXIS_DAT_TREADY = 1'b1;
    wait_drain(100, n);
    settle();
    chk("t4_cnt", 64'(PKT_CNT), {48'd0, 8'd4, 8'd5});

    // 5: single-beat packets, counter wrap 0xFF -> 0x00
    for (int j = 0; j < 250; j++) begin
      send_pkt(0, 1, 100 + j, 1'b0);
      expect_pkt(0, 1, 100 + j, 1'b0);
    end
    wait_drain(1000, n);
    chk("t5_cycles", 64'(n), 64'd500);
    settle();
    chk("t5_cnt_max", 64'(PKT_CNT), {48'd0, 8'd4, 8'hFF});
    send_pkt(0, 1, 999, 1'b0);
    expect_pkt(0, 1, 999, 1'b0);
    wait_drain(50, n);
    settle();
    chk("t5_cnt_wrap", 64'(PKT_CNT), {48'd0, 8'd4, 8'h00});

    // 6: reset mid-packet aborts it; port1 wins afterwards
    send_pkt(0, 4, 6, 1'b0);
    exp_q.push_back(mk(0, 0, 1'b0, 6, 1'b0));
    exp_q.push_back(mk(0, 1, 1'b0, 6, 1'b0));
    wait_src0(3);
    @(posedge ACLK); #2;
    chk("t6_beat2_offered", 64'(M_AXIS_DAT_TVALID), 64'd1);
    ARESETN = 1'b0;
    #1;
    chk("t6_abort_mvalid", 64'(M_AXIS_DAT_TVALID), 64'd0);
    chk("t6_abort_grant", 64'(GRANT), 64'd0);
    chk("t6_abort_tready", 64'(S_AXIS_DAT_TREADY), 64'd0);
    chk("t6_abort_tdata", 64'(|M_AXIS_DAT_TDATA), 64'd0);
    src_q0.delete();
    send_pkt(1, 1, 7, 1'b0);
    expect_pkt(1, 1, 7, 1'b0);
    repeat (2) begin @(negedge ACLK); #1; end
    chk("t6_cnt_reset", 64'(PKT_CNT), 64'd0);
    ARESETN = 1'b1;
    settle();
    chk("t6_grant_p1", 64'(GRANT), 64'b10);
    wait_drain(50, n);
    settle();
    chk("t6_cnt", 64'(PKT_CNT), {48'd0, 8'd1, 8'd0});

    chk("grant_onehot", 64'(gnt_err), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
